// File: rtl/fp_elastic_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_elastic_pipe_reg_pkg
// Purpose  : Shared definitions for the FP stage pipeline registers.
//            Holds the layout of the add->normalize stage bundle.
//            Producer and consumer stages pack and unpack through these
//            definitions only.
// Revision : 1.0  initial release
// ============================================================================
package fp_elastic_pipe_reg_pkg;

    // Add->norm bundle, MSB first.
    typedef struct packed {
        logic [1:0]  rm;
        logic        sign;
        logic [9:0]  exp10;
        logic        is_nan;
        logic        is_inf;
        logic [22:0] inf_nan_frac;
        logic [47:0] z48;
    } add_norm_bundle_t;

    localparam int ADD_NORM_W = $bits(add_norm_bundle_t);   // 86

    // Field widths
    localparam int RM_W           = 2;
    localparam int EXP10_W        = 10;
    localparam int INF_NAN_FRAC_W = 23;
    localparam int Z48_W          = 48;

    // Field LSB offsets within the packed bundle
    localparam int Z48_LSB          = 0;
    localparam int INF_NAN_FRAC_LSB = Z48_LSB + Z48_W;                   // 48
    localparam int IS_INF_BIT       = INF_NAN_FRAC_LSB + INF_NAN_FRAC_W; // 71
    localparam int IS_NAN_BIT       = IS_INF_BIT + 1;                    // 72
    localparam int EXP10_LSB        = IS_NAN_BIT + 1;                    // 73
    localparam int SIGN_BIT         = EXP10_LSB + EXP10_W;               // 83
    localparam int RM_LSB           = SIGN_BIT + 1;                      // 84

endpackage : fp_elastic_pipe_reg_pkg
`default_nettype wire

// File: rtl/fp_elastic_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : fp_elastic_pipe_reg
// Purpose  : DEPTH-entry valid/ready elastic buffer between FP datapath
//            stages. Adds a synchronous flush, a global hold and an
//            occupancy count. in_ready depends only on registered state
//            and on flush/hold. There is no out_ready -> in_ready path.
// Ports    : clk       rising-edge clock
//            clrn      asynchronous active-low reset
//            flush     synchronous discard of all entries
//            hold      freeze: no push, no pop, contents retained
//            in_valid / in_ready / in_data    producer handshake + bundle
//            out_valid / out_ready / out_data consumer handshake + bundle
//            count     entries currently stored (0..DEPTH)
// Revision : 1.0  initial release
// ============================================================================
module fp_elastic_pipe_reg
    import fp_elastic_pipe_reg_pkg::*;
#(
    parameter int DATA_W = ADD_NORM_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    // Elaboration-time parameter sanity.
    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
        $error("fp_elastic_pipe_reg: DEPTH must be in 2..8");
    end
    if (CNT_W < $clog2(DEPTH + 1)) begin : g_bad_cnt_w
        $error("fp_elastic_pipe_reg: CNT_W too narrow to hold DEPTH");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    // Low while reset is asserted and until the first clock after release,
    // so in_ready stays low through reset even though count is zero.
    logic              rst_done_q, rst_done_d;

    logic push;
    logic pop;

    // Full blocks intake even if the consumer pops this cycle: the freed
    // slot is offered one cycle later, keeping out_ready off the in_ready path.
    assign in_ready  = rst_done_q & ~flush & ~hold & (count_q < C_DEPTH);
    assign out_valid = ~flush & ~hold & (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Both already gated by flush/hold through in_ready/out_valid.
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rst_done_d = 1'b1;

        if (flush) begin
            // Storage is left as is; only the bookkeeping is cleared.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rst_done_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rst_done_q <= rst_done_d;
        end
    end

endmodule : fp_elastic_pipe_reg
`default_nettype wire

// File: tb/tb_fp_elastic_pipe_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fp_elastic_pipe_reg
// Purpose  : Self-checking bench for fp_elastic_pipe_reg. A DEPTH=2
//            instance runs a vector table plus streaming and reset
//            sequences. A DEPTH=3 instance runs a pointer-wrap sequence
//            with random consumer stalls.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_elastic_pipe_reg;
    import fp_elastic_pipe_reg_pkg::*;

    localparam int W = ADD_NORM_W;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic         f2, h2, iv2, ir2, ov2, or2;
    logic [W-1:0] id2, od2;
    logic [3:0]   cnt2;
    // DEPTH=3 instance
    logic         f3, h3, iv3, ir3, ov3, or3;
    logic [W-1:0] id3, od3;
    logic [3:0]   cnt3;

    fp_elastic_pipe_reg #(.DATA_W(W), .DEPTH(2), .CNT_W(4)) dut2 (
        .clk(clk), .clrn(clrn), .flush(f2), .hold(h2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cnt2)
    );

    fp_elastic_pipe_reg #(.DATA_W(W), .DEPTH(3), .CNT_W(4)) dut3 (
        .clk(clk), .clrn(clrn), .flush(f3), .hold(h3),
        .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .count(cnt3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       fl, ho, iv, ordy;
        logic [7:0] din;
        logic       e_ir, e_ov;
        logic [7:0] e_od;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vt[14];

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] q[$];
        int sent, got, mcnt;
        logic mpush, mpop;

        //        fl ho iv or din    ir ov od     cnt
        vt[0]  = '{0, 0, 1, 0, 8'h0A, 1, 0, 8'h00, 4'd0};  // first push, stale reset data
        vt[1]  = '{0, 0, 1, 0, 8'h0B, 1, 1, 8'h0A, 4'd1};  // second push -> full
        vt[2]  = '{0, 0, 1, 1, 8'h0C, 0, 1, 8'h0A, 4'd2};  // full: pop 0xA, no push
        vt[3]  = '{0, 0, 1, 0, 8'h0C, 1, 1, 8'h0B, 4'd1};  // freed slot offered now
        vt[4]  = '{1, 0, 1, 1, 8'h0E, 0, 0, 8'h0B, 4'd2};  // flush with 0xE offered
        vt[5]  = '{0, 0, 0, 1, 8'h00, 1, 0, 8'h0C, 4'd0};  // empty, stale mem[0]=0xC
        vt[6]  = '{0, 0, 1, 0, 8'h05, 1, 0, 8'h0C, 4'd0};  // push 0x5
        vt[7]  = '{0, 1, 1, 1, 8'h06, 0, 0, 8'h05, 4'd1};  // hold x3
        vt[8]  = '{0, 1, 1, 1, 8'h06, 0, 0, 8'h05, 4'd1};
        vt[9]  = '{0, 1, 1, 1, 8'h06, 0, 0, 8'h05, 4'd1};
        vt[10] = '{0, 0, 0, 1, 8'h00, 1, 1, 8'h05, 4'd1};  // 0x5 presented first
        vt[11] = '{0, 0, 0, 0, 8'h00, 1, 0, 8'h0B, 4'd0};  // empty, stale mem[1]
        vt[12] = '{1, 1, 1, 1, 8'h07, 0, 0, 8'h0B, 4'd0};  // flush+hold: flush wins
        vt[13] = '{0, 0, 0, 0, 8'h00, 1, 0, 8'h05, 4'd0};  // pointers back to 0

        f2 = 0; h2 = 0; iv2 = 0; or2 = 0; id2 = '0;
        f3 = 0; h3 = 0; iv3 = 0; or3 = 0; id3 = '0;

        // ---------------- reset state ----------------
        clrn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", ir2, 0);
        chk("rst_out_valid", ov2, 0);
        chk("rst_out_data", od2, 0);
        chk("rst_count", cnt2, 0);
        clrn = 1;
        #1 chk("rel_in_ready_before_clk", ir2, 0);
        @(negedge clk);
        chk("rel_in_ready_after_clk", ir2, 1);

        // ---------------- vector table (DEPTH=2) ----------------
        for (int i = 0; i < 14; i++) begin
            f2 = vt[i].fl; h2 = vt[i].ho; iv2 = vt[i].iv; or2 = vt[i].ordy;
            id2 = W'(vt[i].din);
            #1;
            chk($sformatf("vec%0d_in_ready", i),  ir2,  vt[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), ov2,  vt[i].e_ov);
            chk($sformatf("vec%0d_out_data", i),  od2,  W'(vt[i].e_od));
            chk($sformatf("vec%0d_count", i),     cnt2, vt[i].e_cnt);
            @(negedge clk);
        end
        f2 = 0; h2 = 0; iv2 = 0; or2 = 0;

        // ---------------- streaming 16 beats, 1 beat/cycle ----------------
        for (int i = 0; i < 18; i++) begin
            iv2 = (i < 16);
            id2 = W'(i + 1);
            or2 = 1;
            #1;
            if (i == 0) begin
                chk("stream_first_bubble", ov2, 0);
            end else if (i <= 16) begin
                chk($sformatf("stream%0d_out_valid", i), ov2, 1);
                chk($sformatf("stream%0d_out_data", i),  od2, W'(i));
            end
            if (i < 16) chk($sformatf("stream%0d_in_ready", i), ir2, 1);
            @(negedge clk);
        end
        iv2 = 0; or2 = 0;

        // ---------------- async reset mid-stream with count=2 ----------------
        iv2 = 1; id2 = W'(8'h21);
        @(negedge clk);
        id2 = W'(8'h22);
        @(negedge clk);
        iv2 = 0;
        #1;
        chk("prerst_count", cnt2, 2);
        chk("prerst_out_data", od2, W'(8'h21));
        #2 clrn = 0;
        #1;
        chk("midrst_count", cnt2, 0);
        chk("midrst_out_valid", ov2, 0);
        chk("midrst_out_data", od2, 0);
        chk("midrst_in_ready", ir2, 0);
        @(negedge clk);
        clrn = 1;
        #1 chk("rel2_in_ready_before_clk", ir2, 0);
        @(negedge clk);
        chk("rel2_in_ready_after_clk", ir2, 1);

        // ---------------- wrap test on DEPTH=3 with random stalls ----------------
        sent = 0; got = 0; mcnt = 0;
        for (int cyc = 0; cyc < 200 && got < 7; cyc++) begin
            iv3 = (sent < 7);
            id3 = W'(8'h11 + sent);
            or3 = 1'($urandom_range(0, 1));
            #1;
            chk("wrap_in_ready",  ir3,  mcnt < 3);
            chk("wrap_out_valid", ov3,  mcnt != 0);
            chk("wrap_count",     cnt3, W'(mcnt));
            if (mcnt != 0 && or3) chk("wrap_out_data", od3, q[0]);
            mpush = iv3 && (mcnt < 3);
            mpop  = or3 && (mcnt != 0);
            if (mpop) begin
                void'(q.pop_front());
                got++;
            end
            if (mpush) begin
                q.push_back(id3);
                sent++;
            end
            mcnt = mcnt + int'(mpush) - int'(mpop);
            @(negedge clk);
        end
        iv3 = 0; or3 = 0;
        chk("wrap_all_beats_delivered", W'(got), W'(7));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fp_elastic_pipe_reg
`default_nettype wire
